sync_fifo: RTL and testbench
============================

# sync_fifo

Single-clock, parametrised FIFO built on a dual-port register array, with occupancy count, programmable almost-full/almost-empty flags and a selectable read mode: standard registered-read or first-word-fall-through. It is the general-purpose buffer for same-domain datapaths and complements the dual-clock FIFO used at clock-domain crossings. It owns pointer, flag and count logic, so clients see a complete FIFO rather than a bare memory.

## Interface
Parameters:
- DATASIZE, 32, data word width
- ADDRSIZE, 6, address width; depth = 2^ADDRSIZE
- AFULL_THRESH, 2^ADDRSIZE-2, almost_full asserts when count >= this
- AEMPTY_THRESH, 2, almost_empty asserts when count <= this
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- winc  in  1  write request
- wdata  in  DATASIZE  write data
- rinc  in  1  read request / pop
- rdata  out  DATASIZE  read data
- full  out  1  FIFO holds 2^ADDRSIZE words
- empty  out  1  FIFO holds 0 words
- almost_full  out  1  count >= AFULL_THRESH
- almost_empty  out  1  count <= AEMPTY_THRESH
- count  out  ADDRSIZE+1  current occupancy, 0..2^ADDRSIZE
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Pointers wptr, rptr are ADDRSIZE+1 bits binary. The low ADDRSIZE bits address the array. The MSB is the wrap bit.
- empty = (wptr == rptr). full = MSBs differ and low bits equal. Natural wrap, with no special case at 2^ADDRSIZE.
- Write accepted iff winc && !full: mem[wptr] <= wdata, wptr++.
- Read accepted iff rinc && !empty: rptr++.
- Simultaneous request handling:
  - When neither full nor empty, both are accepted and count is unchanged.
  - When full, only the read is accepted; the write is dropped.
  - When empty, only the write is accepted; the read is ignored.
- count: +1 on write-only, -1 on read-only, unchanged otherwise. It is a registered output.
- FWFT=0: on an accepted read, rdata <= mem[rptr] and is valid the cycle after the read. rdata holds its value otherwise.
- FWFT=1: rdata = mem[rptr] continuously and is valid whenever empty=0. rinc pops the current word.
- Dropped operations never alter memory, pointers or count.
- Reset is asynchronous and takes effect mid-operation. It produces:
  - wptr = rptr = 0, count = 0, empty = 1, full = 0
  - almost_empty = 1, almost_full = 0
  - rdata = 0 (FWFT=0), overflow = underflow = 0
- Memory contents are not reset.

## Timing
- Flags and count are functions of registered state only. They update on the clock edge following the accepted operation, with no combinational path from winc/rinc.
- Write to empty FIFO: empty falls 1 cycle later. With FWFT=1, rdata is valid in that same cycle.
- FWFT=0 read latency: 1 cycle from the accepted rinc to rdata.
- Full to not-full: one cycle after an accepted read. Back-to-back write then succeeds in the next cycle.
- Sustained throughput: 1 write + 1 read per cycle.

## Configuration
- SYNC_FIFO_ERR_EN defined:
  - overflow sets on winc && full; underflow sets on rinc && empty.
  - Both flags are sticky until err_clr or reset.
  - A set event in the same cycle as err_clr wins.
- SYNC_FIFO_ERR_EN undefined: overflow and underflow are tied to 0, err_clr is ignored, and no error registers are synthesised. The ports remain present.

## Structure
- Package sync_fifo_pkg holds:
  - default DATASIZE/ADDRSIZE constants
  - the read-mode encodings RD_STD = 0, RD_FWFT = 1
  - a function computing ptr-difference count width
- One sub-module, sync_fifo_ram:
  - 2^ADDRSIZE × DATASIZE array
  - synchronous write port with enable
  - combinational read port
- All control logic lives in sync_fifo.

## Test plan
Bench configuration: DATASIZE=8, ADDRSIZE=2 (depth 4), AFULL_THRESH=3, AEMPTY_THRESH=1.
- Reset mid-stream: write 0x11, 0x22, then assert rst_n=0 → count=0, empty=1, rdata=0. After release, a read is ignored and underflow=1 (with macro).
- Fill and wrap:
  - Write 0xA0..0xA3 → full=1, almost_full=1 after the 3rd write, count=4.
  - A 5th write is dropped and overflow=1.
  - Read 4 words → 0xA0..0xA3 in order, empty=1.
- Pointer wrap: repeat write-2/read-2 five times with data 0x00..0x09 → reads return 0x00..0x09 in order and count never exceeds 2.
- Simultaneous at full: with the FIFO full, assert winc+rinc with wdata=0x55 → read accepted, write dropped, count=3, 0x55 never read.
- Simultaneous mid-level: at count=2, hold winc+rinc for 10 cycles → count stays 2 and data order is preserved.
- FWFT=1:
  - Write 0x7E to an empty FIFO → next cycle empty=0, rdata=0x7E without rinc.
  - rinc → empty=1.
  - err_clr then clears overflow/underflow to 0.

Source files
------------

// File: rtl/sync_fifo_pkg.sv
// Shared definitions for sync_fifo: default geometry, read-mode encodings
// and the helper that sizes the occupancy counter.
package sync_fifo_pkg;

  localparam int DEF_DATASIZE = 32;
  localparam int DEF_ADDRSIZE = 6;

  typedef enum logic {
    RD_STD  = 1'b0,
    RD_FWFT = 1'b1
  } rd_mode_e;

  // Occupancy runs 0..2^addrsize inclusive, so it needs one bit beyond the address.
  function automatic int cnt_width(input int addrsize);
    return addrsize + 1;
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Storage array for sync_fifo: 2^ADDRSIZE x DATASIZE words, synchronous write
// with enable, combinational read. Contents are deliberately not reset.
module sync_fifo_ram #(
  parameter int DATASIZE = 32,
  parameter int ADDRSIZE = 6
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);

  logic [DATASIZE-1:0] mem [2**ADDRSIZE];

  // Write port: store the word when the controller accepts a write.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointer, count and flag control around sync_fifo_ram.
// FWFT selects registered read (RD_STD) or first-word-fall-through (RD_FWFT).
// Optional sticky overflow/underflow error flags are built when the macro
// SYNC_FIFO_ERR_EN is defined; otherwise those outputs are tied low.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATASIZE      = DEF_DATASIZE,
  parameter int ADDRSIZE      = DEF_ADDRSIZE,
  parameter int AFULL_THRESH  = (1 << ADDRSIZE) - 2,
  parameter int AEMPTY_THRESH = 2,
  parameter int FWFT          = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            winc,
  input  logic [DATASIZE-1:0]             wdata,
  input  logic                            rinc,
  output logic [DATASIZE-1:0]             rdata,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            almost_empty,
  output logic [cnt_width(ADDRSIZE)-1:0]  count,
  output logic                            overflow,
  output logic                            underflow,
  input  logic                            err_clr
);

  localparam int CW = cnt_width(ADDRSIZE);
  localparam logic [ADDRSIZE:0] PTR_ONE = 1;
  localparam logic [CW-1:0]     CNT_ONE = 1;
  localparam logic [CW-1:0]     AF_LVL  = CW'(AFULL_THRESH);
  localparam logic [CW-1:0]     AE_LVL  = CW'(AEMPTY_THRESH);

  logic [ADDRSIZE:0]   wptr, rptr;
  logic [CW-1:0]       count_q;
  logic [DATASIZE-1:0] ram_rdata;
  logic                wr_en, rd_en;

  // Flags depend only on registered pointers/count, never on winc/rinc.
  assign empty        = (wptr == rptr);
  assign full         = (wptr[ADDRSIZE] != rptr[ADDRSIZE]) &&
                        (wptr[ADDRSIZE-1:0] == rptr[ADDRSIZE-1:0]);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;

  // A full FIFO drops writes and an empty one ignores reads, so a
  // simultaneous request at either boundary resolves to a single operation.
  assign wr_en = winc && !full;
  assign rd_en = rinc && !empty;

  sync_fifo_ram #(
    .DATASIZE (DATASIZE),
    .ADDRSIZE (ADDRSIZE)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wptr[ADDRSIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr[ADDRSIZE-1:0]),
    .rdata (ram_rdata)
  );

  // Pointers advance on accepted operations and wrap naturally via the MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + PTR_ONE;
      if (rd_en) rptr <= rptr + PTR_ONE;
    end
  end

  // Occupancy: moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

  generate
    if (FWFT == int'(RD_FWFT)) begin : g_fwft
      assign rdata = ram_rdata;
    end else begin : g_std
      logic [DATASIZE-1:0] rdata_q;
      // Registered read: capture the head word on each accepted pop, else hold.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     rdata_q <= '0;
        else if (rd_en) rdata_q <= ram_rdata;
      end
      assign rdata = rdata_q;
    end
  endgenerate

`ifdef SYNC_FIFO_ERR_EN
  logic ovf_q, udf_q;
  // Sticky error flags; a new error event outranks a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (winc && full)  ovf_q <= 1'b1;
      else if (err_clr)  ovf_q <= 1'b0;
      if (rinc && empty) udf_q <= 1'b1;
      else if (err_clr)  udf_q <= 1'b0;
    end
  end
  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: one standard-read instance and one FWFT
// instance, both depth 4, 8-bit data, AFULL_THRESH=3, AEMPTY_THRESH=1.
module tb_sync_fifo;

`ifdef SYNC_FIFO_ERR_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_winc = 0, s_rinc = 0, s_err_clr = 0;
  logic [7:0] s_wdata = '0, s_rdata;
  logic       s_full, s_empty, s_af, s_ae, s_ovf, s_udf;
  logic [2:0] s_count;

  logic       f_winc = 0, f_rinc = 0, f_err_clr = 0;
  logic [7:0] f_wdata = '0, f_rdata;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [2:0] f_count;

  int total = 0;
  int bad = 0;

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(0)) dut_std (
    .clk(clk), .rst_n(rst_n), .winc(s_winc), .wdata(s_wdata), .rinc(s_rinc),
    .rdata(s_rdata), .full(s_full), .empty(s_empty), .almost_full(s_af),
    .almost_empty(s_ae), .count(s_count), .overflow(s_ovf), .underflow(s_udf),
    .err_clr(s_err_clr)
  );

  sync_fifo #(.DATASIZE(8), .ADDRSIZE(2), .AFULL_THRESH(3), .AEMPTY_THRESH(1), .FWFT(1)) dut_fwft (
    .clk(clk), .rst_n(rst_n), .winc(f_winc), .wdata(f_wdata), .rinc(f_rinc),
    .rdata(f_rdata), .full(f_full), .empty(f_empty), .almost_full(f_af),
    .almost_empty(f_ae), .count(f_count), .overflow(f_ovf), .underflow(f_udf),
    .err_clr(f_err_clr)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic s_write(input logic [7:0] d);
    s_winc = 1; s_wdata = d; step(); s_winc = 0;
  endtask

  task automatic s_read();
    s_rinc = 1; step(); s_rinc = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    step(); step();
    total++; if (s_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", s_count); end
    total++; if (s_empty !== 1'b1 || s_full !== 1'b0) begin bad++; $display("FAIL rst_empty_full: got e=%b f=%b want e=1 f=0", s_empty, s_full); end
    total++; if (s_ae !== 1'b1 || s_af !== 1'b0) begin bad++; $display("FAIL rst_almost: got ae=%b af=%b want ae=1 af=0", s_ae, s_af); end
    total++; if (s_rdata !== 8'h00) begin bad++; $display("FAIL rst_rdata: got %h want 00", s_rdata); end
    total++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin bad++; $display("FAIL rst_err: got ovf=%b udf=%b want 0 0", s_ovf, s_udf); end
    rst_n = 1;
    step();
    s_write(8'h11);
    s_write(8'h22);
    s_read();
    total++; if (s_rdata !== 8'h11 || s_count !== 3'd1) begin bad++; $display("FAIL pre_rst_read: got rdata=%h count=%0d want 11 1", s_rdata, s_count); end
    #2 rst_n = 0;
    #1;
    total++; if (s_count !== 3'd0 || s_empty !== 1'b1) begin bad++; $display("FAIL midrst_state: got count=%0d empty=%b want 0 1", s_count, s_empty); end
    total++; if (s_rdata !== 8'h00) begin bad++; $display("FAIL midrst_rdata: got %h want 00", s_rdata); end
    step();
    rst_n = 1;
    s_read();
    total++; if (s_count !== 3'd0 || s_empty !== 1'b1) begin bad++; $display("FAIL post_rst_read: got count=%0d empty=%b want 0 1", s_count, s_empty); end
    total++; if (s_udf !== ERR) begin bad++; $display("FAIL underflow_set: got %b want %b", s_udf, ERR); end
    s_err_clr = 1; step(); s_err_clr = 0;
    total++; if (s_udf !== 1'b0) begin bad++; $display("FAIL underflow_clr: got %b want 0", s_udf); end
  endtask

  task automatic test_fill_wrap();
    for (int i = 0; i < 4; i++) begin
      s_write(8'(8'hA0 + i));
      total++; if (s_count !== 3'(i + 1)) begin bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", i, s_count, i + 1); end
      total++; if (s_af !== (i >= 2) || s_ae !== (i == 0)) begin bad++; $display("FAIL fill_almost[%0d]: got af=%b ae=%b", i, s_af, s_ae); end
      total++; if (s_full !== (i == 3)) begin bad++; $display("FAIL fill_full[%0d]: got %b want %b", i, s_full, (i == 3)); end
    end
    s_write(8'hFF);
    total++; if (s_count !== 3'd4 || s_full !== 1'b1) begin bad++; $display("FAIL drop_write: got count=%0d full=%b want 4 1", s_count, s_full); end
    total++; if (s_ovf !== ERR) begin bad++; $display("FAIL overflow_set: got %b want %b", s_ovf, ERR); end
    for (int i = 0; i < 4; i++) begin
      s_read();
      total++; if (s_rdata !== 8'(8'hA0 + i)) begin bad++; $display("FAIL fill_read[%0d]: got %h want %h", i, s_rdata, 8'(8'hA0 + i)); end
    end
    total++; if (s_empty !== 1'b1 || s_ae !== 1'b1 || s_count !== 3'd0) begin bad++; $display("FAIL drained: got empty=%b ae=%b count=%0d", s_empty, s_ae, s_count); end
    s_err_clr = 1; step(); s_err_clr = 0;
    total++; if (s_ovf !== 1'b0) begin bad++; $display("FAIL overflow_clr: got %b want 0", s_ovf); end
  endtask

  task automatic test_ptr_wrap();
    for (int k = 0; k < 5; k++) begin
      s_write(8'(2 * k));
      s_write(8'(2 * k + 1));
      total++; if (s_count !== 3'd2) begin bad++; $display("FAIL wrap_count[%0d]: got %0d want 2", k, s_count); end
      s_read();
      total++; if (s_rdata !== 8'(2 * k)) begin bad++; $display("FAIL wrap_rd0[%0d]: got %h want %h", k, s_rdata, 8'(2 * k)); end
      s_read();
      total++; if (s_rdata !== 8'(2 * k + 1)) begin bad++; $display("FAIL wrap_rd1[%0d]: got %h want %h", k, s_rdata, 8'(2 * k + 1)); end
    end
    total++; if (s_empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", s_empty); end
  endtask

  task automatic test_simul_full();
    for (int i = 0; i < 4; i++) s_write(8'(8'hB0 + i));
    s_winc = 1; s_rinc = 1; s_wdata = 8'h55;
    step();
    s_winc = 0; s_rinc = 0;
    total++; if (s_count !== 3'd3 || s_full !== 1'b0) begin bad++; $display("FAIL simfull_count: got count=%0d full=%b want 3 0", s_count, s_full); end
    total++; if (s_rdata !== 8'hB0) begin bad++; $display("FAIL simfull_rdata: got %h want b0", s_rdata); end
    for (int i = 1; i < 4; i++) begin
      s_read();
      total++; if (s_rdata !== 8'(8'hB0 + i)) begin bad++; $display("FAIL simfull_drain[%0d]: got %h want %h", i, s_rdata, 8'(8'hB0 + i)); end
    end
    s_read();
    total++; if (s_empty !== 1'b1 || s_rdata !== 8'hB3) begin bad++; $display("FAIL simfull_no55: got empty=%b rdata=%h want 1 b3", s_empty, s_rdata); end
  endtask

  task automatic test_simul_mid();
    s_write(8'hC0);
    s_write(8'hC1);
    for (int i = 0; i < 10; i++) begin
      s_winc = 1; s_rinc = 1; s_wdata = 8'(8'hC2 + i);
      step();
      total++; if (s_count !== 3'd2) begin bad++; $display("FAIL simmid_count[%0d]: got %0d want 2", i, s_count); end
      total++; if (s_rdata !== 8'(8'hC0 + i)) begin bad++; $display("FAIL simmid_rdata[%0d]: got %h want %h", i, s_rdata, 8'(8'hC0 + i)); end
    end
    s_winc = 0; s_rinc = 0;
    s_read();
    total++; if (s_rdata !== 8'hCA) begin bad++; $display("FAIL simmid_tail0: got %h want ca", s_rdata); end
    s_read();
    total++; if (s_rdata !== 8'hCB || s_empty !== 1'b1) begin bad++; $display("FAIL simmid_tail1: got %h empty=%b want cb 1", s_rdata, s_empty); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) s_write(8'(8'hD0 + i));
    s_read();
    total++; if (s_full !== 1'b0 || s_rdata !== 8'hD0) begin bad++; $display("FAIL b2b_unfull: got full=%b rdata=%h want 0 d0", s_full, s_rdata); end
    s_write(8'hD4);
    total++; if (s_full !== 1'b1 || s_count !== 3'd4) begin bad++; $display("FAIL b2b_refill: got full=%b count=%0d want 1 4", s_full, s_count); end
    for (int i = 1; i < 5; i++) begin
      s_read();
      total++; if (s_rdata !== 8'(8'hD0 + i)) begin bad++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, s_rdata, 8'(8'hD0 + i)); end
    end
  endtask

  task automatic test_fwft();
    total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL fwft_init_empty: got %b want 1", f_empty); end
    f_winc = 1; f_wdata = 8'h7E; step(); f_winc = 0;
    total++; if (f_empty !== 1'b0 || f_rdata !== 8'h7E) begin bad++; $display("FAIL fwft_fall: got empty=%b rdata=%h want 0 7e", f_empty, f_rdata); end
    step();
    total++; if (f_rdata !== 8'h7E) begin bad++; $display("FAIL fwft_hold: got %h want 7e", f_rdata); end
    f_rinc = 1; step();
    total++; if (f_empty !== 1'b1) begin bad++; $display("FAIL fwft_pop: got empty=%b want 1", f_empty); end
    step(); f_rinc = 0;
    total++; if (f_udf !== ERR) begin bad++; $display("FAIL fwft_udf: got %b want %b", f_udf, ERR); end
    for (int i = 0; i < 4; i++) begin
      f_winc = 1; f_wdata = 8'(8'h01 + i); step();
    end
    f_wdata = 8'hEE; step(); f_winc = 0;
    total++; if (f_full !== 1'b1 || f_count !== 3'd4 || f_rdata !== 8'h01) begin bad++; $display("FAIL fwft_full: got full=%b count=%0d rdata=%h want 1 4 01", f_full, f_count, f_rdata); end
    total++; if (f_ovf !== ERR) begin bad++; $display("FAIL fwft_ovf: got %b want %b", f_ovf, ERR); end
    f_err_clr = 1; step(); f_err_clr = 0;
    total++; if (f_ovf !== 1'b0 || f_udf !== 1'b0) begin bad++; $display("FAIL fwft_errclr: got ovf=%b udf=%b want 0 0", f_ovf, f_udf); end
    for (int i = 0; i < 4; i++) begin
      total++; if (f_rdata !== 8'(8'h01 + i)) begin bad++; $display("FAIL fwft_head[%0d]: got %h want %h", i, f_rdata, 8'(8'h01 + i)); end
      f_rinc = 1; step(); f_rinc = 0;
    end
    f_rinc = 1; f_err_clr = 1; step(); f_rinc = 0; f_err_clr = 0;
    total++; if (f_udf !== ERR) begin bad++; $display("FAIL set_beats_clr: got %b want %b", f_udf, ERR); end
    f_err_clr = 1; step(); f_err_clr = 0;
    total++; if (f_udf !== 1'b0) begin bad++; $display("FAIL fwft_udf_clr: got %b want 0", f_udf); end
  endtask

  initial begin
    test_reset();
    test_fill_wrap();
    test_ptr_wrap();
    test_simul_full();
    test_simul_mid();
    test_back_to_back();
    test_fwft();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
